// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the two writeback request channels and the registered write port.
//   Parameters: DATA_W (write data width) and ADDR_W (register address width).
//   Signals:
//     req0_valid/req0_addr/req0_data/req0_ready   ALU writeback channel
//     req1_valid/req1_addr/req1_data/req1_ready   LSU writeback channel
//     WE3/AD3/WD3                                 register-file write port
//     last_gnt                                    most recently granted requester
//   Modports:
//     master  the requester side (drives requests, observes grants and writes)
//     slave   the arbiter side
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              WE3;
  logic [ADDR_W-1:0] AD3;
  logic [DATA_W-1:0] WD3;
  logic              last_gnt;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  WE3, AD3, WD3, last_gnt
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output WE3, AD3, WD3, last_gnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the ALU (req0) and the
//   load/store unit (req1). Round-robin grant with valid/ready handshake and a
//   one-cycle registered write stage. Writes to x0 are accepted but absorbed.
//   Ports:
//     clk      clock, rising edge
//     rst_n    asynchronous active-low reset
//     bus      regfile_wb_arbiter_if.slave (request channels, WE3/AD3/WD3, last_gnt)
//   Optional feature macro: REGFILE_WB_BYPASS_EN
//     Adds rd_addr1/rd_addr2, rd_in1/rd_in2 inputs and rd_out1/rd_out2 outputs,
//     a combinational write-to-read bypass from the write stage.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave bus
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  input  logic [DATA_W-1:0]   rd_in1,
  input  logic [DATA_W-1:0]   rd_in2,
  output logic [DATA_W-1:0]   rd_out1,
  output logic [DATA_W-1:0]   rd_out2
`endif
);

  // PRI0: req0 wins a tie (last grant went to req1); PRI1: req1 wins a tie.
  typedef enum logic {PRI0, PRI1} state_t;

  state_t            state;
  state_t            state_next;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              we_q;
  logic [ADDR_W-1:0] ad_q;
  logic [DATA_W-1:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PRI0;
    end else begin
      state <= state_next;
    end
  end

  // Grants depend only on the valids and the priority state, so ready never
  // feeds back on itself. The state flips only when a transfer happens.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = state;
    if (bus.req0_valid && bus.req1_valid) begin
      if (state == PRI0) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
    if (grant0) begin
      state_next = PRI1;
    end else if (grant1) begin
      state_next = PRI0;
    end
  end

  assign xfer     = grant0 | grant1;
  assign sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

  // x0 transfers complete the handshake but leave the write port idle;
  // AD3/WD3 only change when a real write is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      ad_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= xfer && (sel_addr != '0);
      if (xfer && (sel_addr != '0)) begin
        ad_q <= sel_addr;
        wd_q <= sel_data;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.WE3        = we_q;
  assign bus.AD3        = ad_q;
  assign bus.WD3        = wd_q;
  assign bus.last_gnt   = (state == PRI0);

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the in-flight write to a reader of the same register in the same
  // cycle; x0 always reads the raw (zero) value.
  always_comb begin
    rd_out1 = rd_in1;
    rd_out2 = rd_in2;
    if (we_q && (ad_q == rd_addr1) && (rd_addr1 != '0)) begin
      rd_out1 = wd_q;
    end
    if (we_q && (ad_q == rd_addr2) && (rd_addr2 != '0)) begin
      rd_out2 = wd_q;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed-vector bench for regfile_wb_arbiter. A behavioural model of the
//   grant rule and write stage is compared against the DUT on every falling
//   edge; literal expectations pin the model at key points.
//   Optional feature macro: REGFILE_WB_BYPASS_EN (bypass ports and checks).
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic check_en = 1'b0;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef REGFILE_WB_BYPASS_EN
  logic [ADDR_W-1:0] rd_addr1 = '0;
  logic [ADDR_W-1:0] rd_addr2 = '0;
  logic [DATA_W-1:0] rd_in1 = '0;
  logic [DATA_W-1:0] rd_in2 = '0;
  logic [DATA_W-1:0] rd_out1;
  logic [DATA_W-1:0] rd_out2;
`endif

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2),
    .rd_in1  (rd_in1),
    .rd_in2  (rd_in2),
    .rd_out1 (rd_out1),
    .rd_out2 (rd_out2)
`endif
  );

  always #5 clk = ~clk;

  // Model state: who was granted last, and the write expected on the port.
  logic              m_last;
  logic              m_we;
  logic [ADDR_W-1:0] m_ad;
  logic [DATA_W-1:0] m_wd;

  // Grant rule: a lone valid wins; on a tie the requester not granted last wins.
  function automatic logic want0();
    return bus.req0_valid && (!bus.req1_valid || m_last);
  endfunction

  function automatic logic want1();
    return bus.req1_valid && (!bus.req0_valid || !m_last);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0, input logic v1,
                               input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    bus.req0_valid = v0;
    bus.req0_addr  = a0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_addr  = a1;
    bus.req1_data  = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Model update: an accepted transfer with a nonzero address becomes the
  // next cycle's write; an accepted transfer of either kind flips priority.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last <= 1'b1;
      m_we   <= 1'b0;
      m_ad   <= '0;
      m_wd   <= '0;
    end else begin
      m_we <= 1'b0;
      if (want0()) begin
        m_last <= 1'b0;
        if (bus.req0_addr != 0) begin
          m_we <= 1'b1;
          m_ad <= bus.req0_addr;
          m_wd <= bus.req0_data;
        end
      end else if (want1()) begin
        m_last <= 1'b1;
        if (bus.req1_addr != 0) begin
          m_we <= 1'b1;
          m_ad <= bus.req1_addr;
          m_wd <= bus.req1_data;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_ready0", {31'd0, bus.req0_ready}, {31'd0, want0()});
      checkOutput("cyc_ready1", {31'd0, bus.req1_ready}, {31'd0, want1()});
      checkOutput("cyc_last_gnt", {31'd0, bus.last_gnt}, {31'd0, m_last});
      checkOutput("cyc_we3", {31'd0, bus.WE3}, {31'd0, m_we});
      if (m_we) begin
        checkOutput("cyc_ad3", {27'd0, bus.AD3}, {27'd0, m_ad});
        checkOutput("cyc_wd3", bus.WD3, m_wd);
      end
`ifdef REGFILE_WB_BYPASS_EN
      checkOutput("cyc_rd_out1", rd_out1,
                  (m_we && m_ad == rd_addr1 && rd_addr1 != 0) ? m_wd : rd_in1);
      checkOutput("cyc_rd_out2", rd_out2,
                  (m_we && m_ad == rd_addr2 && rd_addr2 != 0) ? m_wd : rd_in2);
`endif
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  logic              gnt_seq [4];
  logic [ADDR_W-1:0] ad_seq  [4];

  initial begin
    // Reset with a pending ALU request: readys still computed, no write.
    rst_n = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b0, '0, '0);
    check_en = 1'b1;
    step();
    step();
    #3;
    checkOutput("rst_we3", {31'd0, bus.WE3}, 32'd0);
    checkOutput("rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
    checkOutput("rst_ad3", {27'd0, bus.AD3}, 32'd0);
    checkOutput("rst_wd3", bus.WD3, 32'd0);
    checkOutput("rst_last_gnt", {31'd0, bus.last_gnt}, 32'd1);
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044);
    #3;
    checkOutput("first_gnt_ready0", {31'd0, bus.req0_ready}, 32'd1);
    checkOutput("first_gnt_ready1", {31'd0, bus.req1_ready}, 32'd0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'h0000_0044);
    #3;
    checkOutput("first_wr_ad3", {27'd0, bus.AD3}, 32'd3);
    step();
    idle();
    step();
    step();

    // Single ALU request.
    $display("[TB] single requester");
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    #3;
    checkOutput("single_ready0", {31'd0, bus.req0_ready}, 32'd1);
    step();
    idle();
    #3;
    checkOutput("single_we3", {31'd0, bus.WE3}, 32'd1);
    checkOutput("single_ad3", {27'd0, bus.AD3}, 32'd5);
    checkOutput("single_wd3", bus.WD3, 32'hDEAD_BEEF);
    step();
    #3;
    checkOutput("single_we3_after", {31'd0, bus.WE3}, 32'd0);
    step();

    // x0 write from the LSU is accepted and absorbed.
    $display("[TB] x0 absorb");
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234_5678);
    #3;
    checkOutput("x0_ready1", {31'd0, bus.req1_ready}, 32'd1);
    step();
    idle();
    #3;
    checkOutput("x0_we3", {31'd0, bus.WE3}, 32'd0);
    checkOutput("x0_last_gnt", {31'd0, bus.last_gnt}, 32'd1);
    step();

    // Contention: both valid for four grants.
    $display("[TB] contention");
    applyStimulus(1'b1, 5'd1, 32'hA000_0000, 1'b1, 5'd2, 32'hB000_0000);
    for (int i = 0; i < 4; i++) begin
      #3;
      gnt_seq[i] = bus.req1_ready;
      if (i > 0) ad_seq[i-1] = bus.AD3;
      step();
      if (i == 3) begin
        idle();
      end else if (gnt_seq[i]) begin
        bus.req1_data = bus.req1_data + 32'd1;
      end else begin
        bus.req0_data = bus.req0_data + 32'd1;
      end
    end
    #3;
    ad_seq[3] = bus.AD3;
    checkOutput("cont_gnt0", {31'd0, gnt_seq[0]}, 32'd0);
    checkOutput("cont_gnt1", {31'd0, gnt_seq[1]}, 32'd1);
    checkOutput("cont_gnt2", {31'd0, gnt_seq[2]}, 32'd0);
    checkOutput("cont_gnt3", {31'd0, gnt_seq[3]}, 32'd1);
    checkOutput("cont_ad0", {27'd0, ad_seq[0]}, 32'd1);
    checkOutput("cont_ad1", {27'd0, ad_seq[1]}, 32'd2);
    checkOutput("cont_ad2", {27'd0, ad_seq[2]}, 32'd1);
    checkOutput("cont_ad3", {27'd0, ad_seq[3]}, 32'd2);
    checkOutput("cont_wd_last", bus.WD3, 32'hB000_0001);
    step();

    // Asynchronous reset while a write is on the port.
    $display("[TB] async reset mid-write");
    applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0);
    step();
    idle();
    checkOutput("arst_we3_before", {31'd0, bus.WE3}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_we3_after", {31'd0, bus.WE3}, 32'd0);
    checkOutput("arst_ad3_after", {27'd0, bus.AD3}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

`ifdef REGFILE_WB_BYPASS_EN
    // Write-then-read bypass.
    $display("[TB] bypass");
    applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, '0, '0);
    step();
    idle();
    rd_addr1 = 5'd7;
    rd_in1   = 32'h0;
    rd_addr2 = 5'd0;
    rd_in2   = 32'h5555_1111;
    #2;
    checkOutput("byp_rd_out1", rd_out1, 32'hA5A5_A5A5);
    checkOutput("byp_rd_out2", rd_out2, 32'h5555_1111);
    rd_addr1 = 5'd8;
    rd_in1   = 32'h0000_0808;
    #1;
    checkOutput("byp_rd_out1_miss", rd_out1, 32'h0000_0808);
    step();
`endif

    step();
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
